relu_maxpool2x2_stream: RTL and testbench

RELU_MAXPOOL2X2_STREAM -- requirements
Module: relu_maxpool2x2_stream

---
 rtl/fig_pkg.sv | 10 +
 rtl/act_unit.sv | 25 ++
 rtl/relu_maxpool2x2_stream.sv | 109 ++++++++++
 tb/tb_relu_maxpool2x2_stream.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fig_pkg.sv
// Shared constants for the activation / pooling stream blocks.
package fig_pkg;

  // Default signed fixed-point pixel width used across the pipeline.
  localparam int DEF_DATA_WIDTH = 16;

  // Arithmetic right shift applied to negative pixels by the leaky activation.
  localparam int LEAKY_SHIFT = 3;

endpackage

// File: rtl/act_unit.sv
// Per-pixel activation (combinational).
// Build option: FIGAN_LEAKY_RELU_EN selects leaky ReLU (x >>> LEAKY_SHIFT for
// negative x); when undefined the activation is plain ReLU (negative -> 0).
module act_unit
  import fig_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [DATA_WIDTH-1:0] data_out
);

  // Pass non-negative pixels through; map negative pixels per build option.
  always_comb begin
    data_out = data_in;
    if (data_in[DATA_WIDTH-1]) begin
`ifdef FIGAN_LEAKY_RELU_EN
      data_out = data_in >>> LEAKY_SHIFT;
`else
      data_out = '0;
`endif
    end
  end

endmodule

// File: rtl/relu_maxpool2x2_stream.sv
// Streaming activation followed by 2x2 max-pooling over a raster-order frame.
// Activation is provided by act_unit; build option FIGAN_LEAKY_RELU_EN there
// switches ReLU to leaky ReLU. Odd trailing column/row are dropped.
module relu_maxpool2x2_stream
  import fig_pkg::*;
#(
  parameter int IN_WIDTH   = 14,
  parameter int IN_HEIGHT  = 14,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         last_out
);

  localparam int XW       = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
  localparam int YW       = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int LB_DEPTH = (IN_WIDTH / 2 > 0) ? IN_WIDTH / 2 : 1;
  localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [XW-1:0] X_MAX  = XW'(IN_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(IN_HEIGHT - 1);
  // Right/bottom-most pooled window ends on the last odd column/row.
  localparam logic [XW-1:0] LAST_X = XW'((IN_WIDTH  % 2 == 0) ? IN_WIDTH  - 1 : IN_WIDTH  - 2);
  localparam logic [YW-1:0] LAST_Y = YW'((IN_HEIGHT % 2 == 0) ? IN_HEIGHT - 1 : IN_HEIGHT - 2);

  logic [XW-1:0]                 x;
  logic [YW-1:0]                 y;
  logic signed [DATA_WIDTH-1:0]  hold;
  logic signed [DATA_WIDTH-1:0]  linebuf [LB_DEPTH];
  logic signed [DATA_WIDTH-1:0]  act_px;
  logic signed [DATA_WIDTH-1:0]  lb_rd;
  logic signed [DATA_WIDTH-1:0]  pair_max;
  logic signed [DATA_WIDTH-1:0]  win_max;
  logic [LBW-1:0]                lb_idx;
  logic                          x_end;
  logic                          y_end;

  act_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_act (
    .data_in (data_in),
    .data_out(act_px)
  );

  // Horizontal pair maximum, line-buffer lookup and full 2x2 window maximum.
  always_comb begin
    x_end    = (x == X_MAX);
    y_end    = (y == Y_MAX);
    lb_idx   = LBW'(x >> 1);
    lb_rd    = linebuf[lb_idx];
    pair_max = (act_px > hold) ? act_px : hold;
    win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;
  end

  // Column/row position of the incoming pixel; wraps at the frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (valid_in) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Activated left pixel of each horizontal pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (valid_in && !x[0]) begin
      hold <= act_px;
    end
  end

  // Upper-row pair maxima; every entry is written on an even row before the
  // following odd row reads it, so no reset is needed.
  always_ff @(posedge clk) begin
    if (valid_in && x[0] && !y[0]) begin
      linebuf[lb_idx] <= pair_max;
    end
  end

  // Registered pooled output; valid/last are single-cycle pulses, data holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      if (valid_in && x[0] && y[0]) begin
        valid_out <= 1'b1;
        data_out  <= win_max;
        last_out  <= (x == LAST_X) && (y == LAST_Y);
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool2x2_stream.sv
// Bench for relu_maxpool2x2_stream: 4x4 and 5x5 instances share stimulus;
// outputs are compared against a frame-level pooling model.
module tb_relu_maxpool2x2_stream;

  logic               clk;
  logic               rst;
  logic               vin;
  logic signed [15:0] din;
  logic               vo4, lo4, vo5, lo5;
  logic signed [15:0] do4, do5;

  int total = 0;
  int bad   = 0;
  int spur  = 0;
  int qd4[$], qd5[$];
  bit ql4[$], ql5[$];
  logic pv, pvo4, pvo5;

  relu_maxpool2x2_stream #(.IN_WIDTH(4), .IN_HEIGHT(4), .DATA_WIDTH(16)) dut4 (
    .clk(clk), .rst(rst), .valid_in(vin), .data_in(din),
    .valid_out(vo4), .data_out(do4), .last_out(lo4));

  relu_maxpool2x2_stream #(.IN_WIDTH(5), .IN_HEIGHT(5), .DATA_WIDTH(16)) dut5 (
    .clk(clk), .rst(rst), .valid_in(vin), .data_in(din),
    .valid_out(vo5), .data_out(do5), .last_out(lo5));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int act(input int v);
`ifdef FIGAN_LEAKY_RELU_EN
    return (v < 0) ? (v >>> 3) : v;
`else
    return (v < 0) ? 0 : v;
`endif
  endfunction

  // Collect output pulses; a pulse must follow an accepted pixel and never repeat.
  always @(negedge clk) begin
    if (!rst) begin
      if (vo4) begin
        qd4.push_back(int'(do4));
        ql4.push_back(lo4);
        if (!pv || pvo4) spur++;
      end
      if (vo5) begin
        qd5.push_back(int'(do5));
        ql5.push_back(lo5);
        if (!pv || pvo5) spur++;
      end
    end
    pv   = vin;
    pvo4 = vo4;
    pvo5 = vo5;
  end

  task automatic model(input int w, input int h, input int pix[$],
                       output int ev[$], output bit el[$]);
    int m;
    ev.delete();
    el.delete();
    for (int f = 0; f < pix.size() / (w * h); f++)
      for (int oy = 0; oy < h / 2; oy++)
        for (int ox = 0; ox < w / 2; ox++) begin
          m = -(1 << 30);
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
              if (act(pix[f*w*h + (2*oy+dy)*w + 2*ox+dx]) > m)
                m = act(pix[f*w*h + (2*oy+dy)*w + 2*ox+dx]);
          ev.push_back(m);
          el.push_back(oy == h/2 - 1 && ox == w/2 - 1);
        end
  endtask

  task automatic make_frame(input int w, input int h, input int mode, input int c,
                            inout int pix[$]);
    for (int i = 0; i < w * h; i++) begin
      if (mode == 0)      pix.push_back(i + 1);
      else if (mode == 1) pix.push_back(c);
      else                pix.push_back(int'($urandom_range(0, 400)) - 200);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
  endtask

  task automatic feed(input int pix[$], input int gap_pct);
    for (int i = 0; i < pix.size(); i++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        vin = 1'b0;
        @(posedge clk);
        #1;
      end
      vin = 1'b1;
      din = 16'(pix[i]);
      @(posedge clk);
      #1;
      vin = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    vin = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    qd4.delete(); ql4.delete(); qd5.delete(); ql5.delete();
    spur = 0;
  endtask

  task automatic compare(input string tag, input int w, input int h, input int pix[$]);
    int ev[$];
    bit el[$];
    int gd[$];
    bit gl[$];
    model(w, h, pix, ev, el);
    if (w == 4) begin gd = qd4; gl = ql4; end
    else        begin gd = qd5; gl = ql5; end
    chk({tag, "_count"}, gd.size(), ev.size());
    for (int i = 0; i < ev.size() && i < gd.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), gd[i], ev[i]);
      chk($sformatf("%s_last%0d", tag, i), int'(gl[i]), int'(el[i]));
    end
    chk({tag, "_pulse"}, spur, 0);
  endtask

  task automatic run(input string tag, input int w, input int h, input int mode,
                     input int c, input int frames, input int gap_pct);
    int pix[$];
    do_reset();
    for (int f = 0; f < frames; f++) make_frame(w, h, mode, c, pix);
    feed(pix, gap_pct);
    idle(4);
    compare(tag, w, h, pix);
  endtask

  task automatic chk_ramp4(input string tag);
    int exp_d[4] = '{6, 8, 14, 16};
    chk({tag, "_n"}, qd4.size(), 4);
    for (int i = 0; i < 4 && i < qd4.size(); i++) begin
      chk($sformatf("%s_d%0d", tag, i), qd4[i], exp_d[i]);
      chk($sformatf("%s_l%0d", tag, i), int'(ql4[i]), (i == 3) ? 1 : 0);
    end
  endtask

  initial begin
    int pix[$];
    int lasts;
    int exp_d5[4] = '{7, 9, 17, 19};
    rst = 1'b1;
    vin = 1'b0;
    din = '0;
    pv = 1'b0; pvo4 = 1'b0; pvo5 = 1'b0;
    #12;
    chk("rst_valid", int'(vo4), 0);
    chk("rst_data", int'(do4), 0);
    chk("rst_last", int'(lo4), 0);
    #1 rst = 1'b0;

    // Ramp 1..16, continuous.
    run("ramp4", 4, 4, 0, 0, 1, 0);
    chk_ramp4("ramp4k");
    chk("hold_data", int'(do4), 16);
    chk("hold_valid", int'(vo4), 0);

    // Negative constant frames.
    run("neg5", 4, 4, 1, -5, 1, 0);
    run("neg8", 4, 4, 1, -8, 1, 0);
`ifdef FIGAN_LEAKY_RELU_EN
    chk("neg8_k", int'(do4), -1);
`else
    chk("neg8_k", int'(do4), 0);
`endif

    // Ramp with ~50% gaps.
    run("ramp4g", 4, 4, 0, 0, 1, 50);
    chk_ramp4("ramp4gk");

    // Mid-frame reset after 7 pixels, then a clean frame.
    do_reset();
    pix.delete();
    make_frame(4, 4, 0, 0, pix);
    for (int i = 0; i < 9; i++) pix[i] = 100 + i;
    pix = pix[0:6];
    feed(pix, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", int'(vo4), 0);
    chk("arst_data", int'(do4), 0);
    chk("arst_last", int'(lo4), 0);
    do_reset();
    pix.delete();
    make_frame(4, 4, 0, 0, pix);
    feed(pix, 0);
    idle(4);
    chk_ramp4("after_rst");

    // Odd geometry: trailing column and row dropped.
    run("ramp5", 5, 5, 0, 0, 1, 0);
    chk("ramp5_n", qd5.size(), 4);
    for (int i = 0; i < 4 && i < qd5.size(); i++) begin
      chk($sformatf("ramp5_d%0d", i), qd5[i], exp_d5[i]);
      chk($sformatf("ramp5_l%0d", i), int'(ql5[i]), (i == 3) ? 1 : 0);
    end

    // Back-to-back frames.
    run("b2b", 4, 4, 2, 0, 2, 0);
    lasts = 0;
    foreach (ql4[i]) lasts += int'(ql4[i]);
    chk("b2b_lasts", lasts, 2);

    // Random frames with random gaps.
    for (int k = 0; k < 3; k++) begin
      run($sformatf("rnd4_%0d", k), 4, 4, 2, 0, 2, 30);
      run($sformatf("rnd5_%0d", k), 5, 5, 2, 0, 2, 30);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
